// File: rtl/mux_sel_ctrl_if.sv
// Select-control bundle between the push-button/auto-toggle controller and
// whatever drives or observes it. The controller sits on the slave side.
interface mux_sel_ctrl_if;
    logic       btn;
    logic       auto_en;
    logic       s;
    logic       press;
    logic [7:0] sel_changes;

    modport master (
        output btn,
        output auto_en,
        input  s,
        input  press,
        input  sel_changes
    );

    modport slave (
        input  btn,
        input  auto_en,
        output s,
        output press,
        output sel_changes
    );
endinterface

// File: rtl/mux_sel_ctrl.sv
// Mux select generator: synchronises and debounces a raw push-button, toggles
// the registered select `s` on each clean press and, when auto mode is on,
// every AUTO_PERIOD cycles. A wrapping 8-bit count of select changes is kept
// for display/debug. Every output is a flop; no input reaches an output
// combinationally.
module mux_sel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int AUTO_PERIOD     = 100
) (
    input  logic          clk,
    input  logic          rst,
    mux_sel_ctrl_if.slave bus
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int AU_W = $clog2(AUTO_PERIOD);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AU_W-1:0] AU_LAST = AU_W'(AUTO_PERIOD - 1);

    logic            btn_meta;
    logic            btn_sync;
    logic            btn_db;
    logic            btn_db_d;
    logic [DB_W-1:0] db_cnt;
    logic [AU_W-1:0] auto_cnt;
    logic            s_q;
    logic            press_q;
    logic [7:0]      sel_cnt;

    logic db_rise;
    logic auto_wrap;
    logic toggle;

    // A press is the first cycle the debounced level is seen high after being
    // low; a press and an auto wrap in the same cycle merge into one toggle.
    assign db_rise   = btn_db & ~btn_db_d;
    assign auto_wrap = bus.auto_en && (auto_cnt == AU_LAST);
    assign toggle    = db_rise | auto_wrap;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= bus.btn;
            btn_sync <= btn_meta;
        end
    end

    // Debounce: a new level must hold DEBOUNCE_CYCLES consecutive cycles;
    // any return to the accepted level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_d <= 1'b0;
        end else begin
            btn_db_d <= btn_db;
            if (btn_sync == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Auto-toggle period counter; a press restarts the period so the next
    // automatic toggle is always a full period after the last change.
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_cnt <= '0;
        end else if (!bus.auto_en || db_rise || auto_cnt == AU_LAST) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + AU_W'(1);
        end
    end

    // Registered select, press pulse and change counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= 1'b0;
            press_q <= 1'b0;
            sel_cnt <= 8'd0;
        end else begin
            press_q <= db_rise;
            if (toggle) begin
                s_q     <= ~s_q;
                sel_cnt <= sel_cnt + 8'd1;
            end
        end
    end

    assign bus.s           = s_q;
    assign bus.press       = press_q;
    assign bus.sel_changes = sel_cnt;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Directed bench for mux_sel_ctrl with DEBOUNCE_CYCLES=4, AUTO_PERIOD=8.
// Inputs change 1 ns after a rising edge; outputs are read at the same point.
module tb_mux_sel_ctrl;

    logic clk = 1'b0;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;
    int press_seen;
    int toggles_seen;

    mux_sel_ctrl_if bus ();

    mux_sel_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_PERIOD    (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock: inputs set before the call are sampled at this edge.
    task automatic step();
        logic prev_s;
        prev_s = bus.s;
        @(posedge clk);
        #1;
        if (bus.press === 1'b1) press_seen++;
        if (bus.s !== prev_s) toggles_seen++;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_outs(input string tag, input logic s_exp, input logic p_exp, input logic [7:0] c_exp);
        check_val({tag, ".s"}, {31'd0, bus.s}, {31'd0, s_exp});
        check_val({tag, ".press"}, {31'd0, bus.press}, {31'd0, p_exp});
        check_val({tag, ".sel"}, {24'd0, bus.sel_changes}, {24'd0, c_exp});
    endtask

    initial begin
        press_seen   = 0;
        toggles_seen = 0;

        // Reset held with btn and auto_en active.
        rst         = 1'b1;
        bus.btn     = 1'b1;
        bus.auto_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_outs("reset", 1'b0, 1'b0, 8'd0);
        end

        // Clean press straight out of reset: edges 0..5 quiet, press at edge 6.
        rst         = 1'b0;
        bus.auto_en = 1'b0;
        press_seen  = 0;
        step_n(6);
        check_outs("pre_press", 1'b0, 1'b0, 8'd0);
        check_val("pre_press_cnt", press_seen, 0);
        step();
        check_outs("press_edge6", 1'b1, 1'b1, 8'd1);
        step();
        check_outs("press_gone", 1'b1, 1'b0, 8'd1);

        // Release: no press, no toggle.
        bus.btn      = 1'b0;
        press_seen   = 0;
        toggles_seen = 0;
        step_n(12);
        check_val("release_press", press_seen, 0);
        check_val("release_toggle", toggles_seen, 0);

        // Bounce: 3 high, 1 low, 3 high, low -> never accepted.
        press_seen   = 0;
        toggles_seen = 0;
        bus.btn = 1'b1; step_n(3);
        bus.btn = 1'b0; step_n(1);
        bus.btn = 1'b1; step_n(3);
        bus.btn = 1'b0; step_n(12);
        check_val("bounce_press", press_seen, 0);
        check_outs("bounce", 1'b1, 1'b0, 8'd1);

        // Six steady cycles -> exactly one press.
        press_seen = 0;
        bus.btn = 1'b1; step_n(6);
        bus.btn = 1'b0; step_n(14);
        check_val("steady_press", press_seen, 1);
        check_outs("steady", 1'b0, 1'b0, 8'd2);

        // Auto mode: toggles after the 8th, 16th, 24th sampling edges.
        bus.auto_en = 1'b1;
        step_n(7);
        check_outs("auto_pre", 1'b0, 1'b0, 8'd2);
        step();
        check_outs("auto_t1", 1'b1, 1'b0, 8'd3);
        step_n(8);
        check_outs("auto_t2", 1'b0, 1'b0, 8'd4);
        step_n(8);
        check_outs("auto_t3", 1'b1, 1'b0, 8'd5);

        // Drop auto_en mid-period: no further toggles.
        step_n(4);
        bus.auto_en  = 1'b0;
        toggles_seen = 0;
        step_n(20);
        check_val("auto_off_toggle", toggles_seen, 0);
        check_outs("auto_off", 1'b1, 1'b0, 8'd5);

        // Re-assert: a full period before the next toggle.
        bus.auto_en = 1'b1;
        step_n(7);
        check_outs("reassert_pre", 1'b1, 1'b0, 8'd5);
        step();
        check_outs("reassert_t", 1'b0, 1'b0, 8'd6);

        // Collision: press edge lands on the auto wrap edge.
        step();
        bus.btn      = 1'b1;
        toggles_seen = 0;
        step_n(6);
        check_outs("coll_pre", 1'b0, 1'b0, 8'd6);
        step();
        check_outs("coll", 1'b1, 1'b1, 8'd7);
        check_val("coll_once", toggles_seen, 1);
        step_n(7);
        check_outs("coll_next_pre", 1'b1, 1'b0, 8'd7);
        step();
        check_outs("coll_next", 1'b0, 1'b0, 8'd8);

        // Wrap: 256 auto toggles from a clean reset.
        bus.auto_en = 1'b0;
        bus.btn     = 1'b0;
        rst         = 1'b1;
        step_n(2);
        check_outs("wrap_rst", 1'b0, 1'b0, 8'd0);
        rst         = 1'b0;
        bus.auto_en = 1'b1;
        step_n(255 * 8);
        check_outs("wrap_255", 1'b1, 1'b0, 8'd255);
        step_n(8);
        check_outs("wrap_0", 1'b0, 1'b0, 8'd0);

        // Reset mid-period and mid-debounce; state must not leak past it.
        step_n(3);
        bus.btn = 1'b1;
        step_n(3);
        rst = 1'b1;
        step();
        check_outs("mid_rst", 1'b0, 1'b0, 8'd0);
        rst        = 1'b0;
        press_seen = 0;
        step_n(6);
        check_val("no_stale_press", press_seen, 0);
        check_outs("post_rst_quiet", 1'b0, 1'b0, 8'd0);
        step();
        check_outs("post_rst_press", 1'b1, 1'b1, 8'd1);
        step_n(7);
        check_outs("post_rst_pre_auto", 1'b1, 1'b0, 8'd1);
        step();
        check_outs("post_rst_auto", 1'b0, 1'b0, 8'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
